// File: rtl/m68k_bus_initiator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : m68k_bus_initiator
// Description : 68020-style asynchronous bus initiator; dynamic bus sizing
//               splits a request into 32/16/8-bit port sub-cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module m68k_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqRnW,
    input  logic [1:0]  reqSize,
    input  logic [31:0] reqAddr,
    input  logic [2:0]  reqFC,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    output logic [31:0] rspRData,
    output logic        rspBerr,
    output logic        rspTimeout,
    output logic        rspAlign,
    output logic [31:0] busAddr,
    output logic [1:0]  busSiz,
    output logic [2:0]  busFC,
    output logic        busRnW,
    output logic        nBusAS,
    output logic        nBusDS,
    output logic [31:0] busDataOut,
    output logic        busDataOe,
    input  logic [31:0] busDataIn,
    input  logic [1:0]  nBusDsack,
    input  logic        nBusBerr
);
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_ADDR = 3'd1;
    localparam logic [2:0] c_STRB = 3'd2;
    localparam logic [2:0] c_WDS  = 3'd3;
    localparam logic [2:0] c_WAIT = 3'd4;
    localparam logic [2:0] c_ENDC = 3'd5;
    localparam logic [2:0] c_DONE = 3'd6;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [2:0]  r_state, w_nextState;
    logic [1:0]  r_dsackMeta, r_dsackSync;
    logic        r_berrMeta, r_berrSync;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_rem;
    logic [2:0]  r_fc;
    logic        r_rnw, r_berr, r_timeout, r_align;
    logic [7:0]  r_count;

    logic        w_misaligned;
    logic [2:0]  w_reqBytes;
    logic [31:0] w_reqWdata;
    logic [1:0]  w_offset;
    logic [2:0]  w_portBytes, w_avail, w_consumed;
    logic [31:0] w_laneData, w_rdataNext, w_wdataNext;
    logic        w_ack, w_timeUp;

    // Acknowledge inputs are asynchronous; idle (negated) level after reset.
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_dsackMeta <= 2'b11;
            r_dsackSync <= 2'b11;
            r_berrMeta  <= 1'b1;
            r_berrSync  <= 1'b1;
        end else begin
            r_dsackMeta <= nBusDsack;
            r_dsackSync <= r_dsackMeta;
            r_berrMeta  <= nBusBerr;
            r_berrSync  <= r_berrMeta;
        end
    end

    always_comb begin
        w_misaligned = (reqSize == 2'b10) ? reqAddr[0]
                     : ((reqSize != 2'b01) && (reqAddr[1:0] != 2'b00));
        case (reqSize)
            2'b01:   begin w_reqBytes = 3'd1; w_reqWdata = {reqWData[7:0], 24'd0};  end
            2'b10:   begin w_reqBytes = 3'd2; w_reqWdata = {reqWData[15:0], 16'd0}; end
            default: begin w_reqBytes = 3'd4; w_reqWdata = reqWData;                end
        endcase
        case (r_dsackSync)
            2'b00:   begin w_portBytes = 3'd4; w_offset = r_addr[1:0];         end
            2'b01:   begin w_portBytes = 3'd2; w_offset = {1'b0, r_addr[0]};   end
            default: begin w_portBytes = 3'd1; w_offset = 2'b00;               end
        endcase
        w_avail    = w_portBytes - {1'b0, w_offset};
        w_consumed = (r_rem < w_avail) ? r_rem : w_avail;
        // Rotate the addressed lane up to D31 so the consumed bytes sit on top.
        w_laneData = busDataIn << {w_offset, 3'b000};
        case (w_consumed)
            3'd1: begin
                w_rdataNext = {r_rdata[23:0], w_laneData[31:24]};
                w_wdataNext = {r_wdata[23:0], 8'd0};
            end
            3'd2: begin
                w_rdataNext = {r_rdata[15:0], w_laneData[31:16]};
                w_wdataNext = {r_wdata[15:0], 16'd0};
            end
            3'd3: begin
                w_rdataNext = {r_rdata[7:0], w_laneData[31:8]};
                w_wdataNext = {r_wdata[7:0], 24'd0};
            end
            default: begin
                w_rdataNext = w_laneData;
                w_wdataNext = 32'd0;
            end
        endcase
        w_ack    = (r_dsackSync != 2'b11);
        w_timeUp = (r_count >= c_TIMEOUT);
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) r_state <= c_IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        reqReady    = 1'b0;
        rspValid    = 1'b0;
        nBusAS      = 1'b1;
        nBusDS      = 1'b1;
        busDataOe   = 1'b0;
        case (r_state)
            c_IDLE: begin
                reqReady = 1'b1;
                if (reqValid) w_nextState = w_misaligned ? c_DONE : c_ADDR;
            end
            c_ADDR: begin
                busDataOe = ~r_rnw;
                if (!w_ack && r_berrSync) w_nextState = c_STRB;
            end
            c_STRB: begin
                nBusAS      = 1'b0;
                nBusDS      = ~r_rnw;
                busDataOe   = ~r_rnw;
                w_nextState = r_rnw ? c_WAIT : c_WDS;
            end
            c_WDS: begin
                nBusAS      = 1'b0;
                nBusDS      = 1'b0;
                busDataOe   = 1'b1;
                w_nextState = c_WAIT;
            end
            c_WAIT: begin
                nBusAS    = 1'b0;
                nBusDS    = 1'b0;
                busDataOe = ~r_rnw;
                if (!r_berrSync || w_ack || w_timeUp) w_nextState = c_ENDC;
            end
            c_ENDC: begin
                busDataOe   = ~r_rnw;
                w_nextState = (r_berr || r_timeout || (r_rem == 3'd0)) ? c_DONE : c_ADDR;
            end
            c_DONE: begin
                rspValid    = 1'b1;
                w_nextState = c_IDLE;
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_rem     <= 3'd0;
            r_fc      <= 3'd0;
            r_rnw     <= 1'b1;
            r_berr    <= 1'b0;
            r_timeout <= 1'b0;
            r_align   <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: if (reqValid) begin
                    r_addr    <= reqAddr;
                    r_wdata   <= w_reqWdata;
                    r_rdata   <= 32'd0;
                    r_rem     <= w_reqBytes;
                    r_fc      <= reqFC;
                    r_rnw     <= reqRnW;
                    r_berr    <= 1'b0;
                    r_timeout <= 1'b0;
                    r_align   <= w_misaligned;
                end
                c_ADDR:        r_count <= 8'd0;
                c_STRB, c_WDS: r_count <= r_count + 8'd1;
                c_WAIT: begin
                    r_count <= r_count + 8'd1;
                    if (!r_berrSync) begin
                        r_berr <= 1'b1;
                    end else if (w_ack) begin
                        r_addr  <= r_addr + {29'd0, w_consumed};
                        r_rem   <= r_rem - w_consumed;
                        r_wdata <= w_wdataNext;
                        if (r_rnw) r_rdata <= w_rdataNext;
                    end else if (w_timeUp) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rspRData   = r_rdata;
        rspBerr    = rspValid & r_berr;
        rspTimeout = rspValid & r_timeout;
        rspAlign   = rspValid & r_align;
        busAddr    = r_addr;
        busSiz     = r_rem[1:0];
        busFC      = r_fc;
        busRnW     = r_rnw;
        // Short remainders are replicated so every port width sees them on its lanes.
        case (r_rem)
            3'd1:    busDataOut = {4{r_wdata[31:24]}};
            3'd2:    busDataOut = {2{r_wdata[31:16]}};
            default: busDataOut = r_wdata;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_initiator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_m68k_bus_initiator
// Description : Directed bench with bus responder and response scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_m68k_bus_initiator;
    logic        sysClk, sysReset;
    logic        reqValid, reqReady, reqRnW;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWData;
    logic [2:0]  reqFC;
    logic        rspValid, rspBerr, rspTimeout, rspAlign;
    logic [31:0] rspRData;
    logic [31:0] busAddr, busDataOut, busDataIn;
    logic [1:0]  busSiz, nBusDsack;
    logic [2:0]  busFC;
    logic        busRnW, nBusAS, nBusDS, busDataOe, nBusBerr;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  siz;
        logic        rnw;
        logic [31:0] wexp;
        logic [31:0] wmask;
        logic [1:0]  dsack;
        logic        berrN;
        logic [31:0] rdata;
    } busEnt_t;

    typedef struct {
        logic [31:0] data;
        logic        berr;
        logic        tmo;
        logic        align;
    } rsp_t;

    busEnt_t busExp[$];
    rsp_t    rspQ[$];
    int      checks = 0;
    int      errors = 0;
    int      subCycles = 0;

    m68k_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .sysClk(sysClk), .sysReset(sysReset),
        .reqValid(reqValid), .reqReady(reqReady), .reqRnW(reqRnW),
        .reqSize(reqSize), .reqAddr(reqAddr), .reqFC(reqFC), .reqWData(reqWData),
        .rspValid(rspValid), .rspRData(rspRData), .rspBerr(rspBerr),
        .rspTimeout(rspTimeout), .rspAlign(rspAlign),
        .busAddr(busAddr), .busSiz(busSiz), .busFC(busFC), .busRnW(busRnW),
        .nBusAS(nBusAS), .nBusDS(nBusDS), .busDataOut(busDataOut),
        .busDataOe(busDataOe), .busDataIn(busDataIn),
        .nBusDsack(nBusDsack), .nBusBerr(nBusBerr)
    );

    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushBus(input logic [31:0] addr, input logic [1:0] siz, input logic rnw,
                           input logic [31:0] wexp, input logic [31:0] wmask,
                           input logic [1:0] dsack, input logic berrN, input logic [31:0] rdata);
        busExp.push_back('{addr, siz, rnw, wexp, wmask, dsack, berrN, rdata});
    endtask

    // Bus slave: answers each address-strobe assertion from the expected queue.
    initial begin
        busEnt_t e;
        bit active;
        active    = 1'b0;
        nBusDsack = 2'b11;
        nBusBerr  = 1'b1;
        busDataIn = 32'd0;
        forever begin
            @(negedge sysClk);
            if (sysReset) begin
                active    = 1'b0;
                nBusDsack = 2'b11;
                nBusBerr  = 1'b1;
            end else if (!nBusAS && !active) begin
                active = 1'b1;
                subCycles++;
                check("subcyclePending", 32'(busExp.size() != 0), 32'd1);
                if (busExp.size() != 0) begin
                    e = busExp.pop_front();
                    check("busAddr", busAddr, e.addr);
                    check("busSiz", 32'(busSiz), 32'(e.siz));
                    check("busRnW", 32'(busRnW), 32'(e.rnw));
                    check("busFC", 32'(busFC), 32'd5);
                    check("nBusDS_strb", 32'(nBusDS), 32'(!e.rnw));
                    check("busDataOe", 32'(busDataOe), 32'(!e.rnw));
                    if (e.wmask != 32'd0)
                        check("busDataOut", busDataOut & e.wmask, e.wexp & e.wmask);
                    nBusDsack = e.dsack;
                    nBusBerr  = e.berrN;
                    busDataIn = e.rdata;
                end
            end else if (nBusAS && active) begin
                active    = 1'b0;
                nBusDsack = 2'b11;
                nBusBerr  = 1'b1;
            end
        end
    end

    task automatic issue(input logic rnw, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge sysClk);
        while (!reqReady && n < 100) begin @(negedge sysClk); n++; end
        check("reqReady_idle", 32'(reqReady), 32'd1);
        reqValid = 1'b1;
        reqRnW   = rnw;
        reqSize  = size;
        reqAddr  = addr;
        reqFC    = 3'd5;
        reqWData = wdata;
        @(negedge sysClk);
        reqValid = 1'b0;
    endtask

    task automatic doReq(input logic rnw, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] expData,
                         input logic eb, input logic et, input logic ea);
        int n;
        rsp_t r;
        rspQ.push_back('{expData, eb, et, ea});
        issue(rnw, size, addr, wdata);
        n = 0;
        while (!rspValid && n < 200) begin @(negedge sysClk); n++; end
        check("rspValid_seen", 32'(rspValid), 32'd1);
        r = rspQ.pop_front();
        check("rspRData", rspRData, r.data);
        check("rspBerr", 32'(rspBerr), 32'(r.berr));
        check("rspTimeout", 32'(rspTimeout), 32'(r.tmo));
        check("rspAlign", 32'(rspAlign), 32'(r.align));
        check("done_nBusAS", 32'(nBusAS), 32'd1);
        check("done_nBusDS", 32'(nBusDS), 32'd1);
        check("done_busDataOe", 32'(busDataOe), 32'd0);
        @(negedge sysClk);
        check("rspValid_pulse", 32'(rspValid), 32'd0);
    endtask

    initial begin
        int s0, n;
        bit seenRsp;
        sysReset = 1'b1;
        reqValid = 1'b0;
        reqRnW   = 1'b1;
        reqSize  = 2'b00;
        reqAddr  = 32'd0;
        reqFC    = 3'd0;
        reqWData = 32'd0;
        repeat (3) @(negedge sysClk);
        sysReset = 1'b0;

        check("rst_reqReady", 32'(reqReady), 32'd1);
        check("rst_nBusAS", 32'(nBusAS), 32'd1);
        check("rst_nBusDS", 32'(nBusDS), 32'd1);
        check("rst_busDataOe", 32'(busDataOe), 32'd0);
        check("rst_rspValid", 32'(rspValid), 32'd0);
        check("rst_rspRData", rspRData, 32'd0);
        check("rst_rspFlags", {29'd0, rspBerr, rspTimeout, rspAlign}, 32'd0);

        // Long read, 32-bit port
        pushBus(32'h1000, 2'b00, 1'b1, 0, 0, 2'b00, 1'b1, 32'hDEADBEEF);
        doReq(1'b1, 2'b00, 32'h1000, 0, 32'hDEADBEEF, 0, 0, 0);

        // Long write, 8-bit port: four byte sub-cycles
        pushBus(32'h2000, 2'b00, 1'b0, 32'h11000000, 32'hFF000000, 2'b10, 1'b1, 0);
        pushBus(32'h2001, 2'b11, 1'b0, 32'h22000000, 32'hFF000000, 2'b10, 1'b1, 0);
        pushBus(32'h2002, 2'b10, 1'b0, 32'h33000000, 32'hFF000000, 2'b10, 1'b1, 0);
        pushBus(32'h2003, 2'b01, 1'b0, 32'h44000000, 32'hFF000000, 2'b10, 1'b1, 0);
        doReq(1'b0, 2'b00, 32'h2000, 32'h11223344, 32'd0, 0, 0, 0);

        // Word read at 0x3002 on 16-bit then 32-bit port
        pushBus(32'h3002, 2'b10, 1'b1, 0, 0, 2'b01, 1'b1, 32'hABCD1234);
        doReq(1'b1, 2'b10, 32'h3002, 0, 32'h0000ABCD, 0, 0, 0);
        pushBus(32'h3002, 2'b10, 1'b1, 0, 0, 2'b00, 1'b1, 32'h5555BEEF);
        doReq(1'b1, 2'b10, 32'h3002, 0, 32'h0000BEEF, 0, 0, 0);

        // Long read on 16-bit port: two halves assembled MSB-first
        pushBus(32'h8000, 2'b00, 1'b1, 0, 0, 2'b01, 1'b1, 32'h1234AAAA);
        pushBus(32'h8002, 2'b10, 1'b1, 0, 0, 2'b01, 1'b1, 32'h5678BBBB);
        doReq(1'b1, 2'b00, 32'h8000, 0, 32'h12345678, 0, 0, 0);

        // Byte read from lane D7:0, byte and word writes replicated
        pushBus(32'h9003, 2'b01, 1'b1, 0, 0, 2'b00, 1'b1, 32'h11223344);
        doReq(1'b1, 2'b01, 32'h9003, 0, 32'h00000044, 0, 0, 0);
        pushBus(32'hA001, 2'b01, 1'b0, 32'h5A5A5A5A, 32'hFFFFFFFF, 2'b00, 1'b1, 0);
        doReq(1'b0, 2'b01, 32'hA001, 32'h0000005A, 32'd0, 0, 0, 0);
        pushBus(32'hB000, 2'b10, 1'b0, 32'h12341234, 32'hFFFFFFFF, 2'b00, 1'b1, 0);
        doReq(1'b0, 2'b10, 32'hB000, 32'h00001234, 32'd0, 0, 0, 0);

        // BERR together with DSACK: berr wins, no further sub-cycles
        s0 = subCycles;
        pushBus(32'h5000, 2'b00, 1'b1, 0, 0, 2'b10, 1'b0, 32'hFFFFFFFF);
        doReq(1'b1, 2'b00, 32'h5000, 0, 32'd0, 1, 0, 0);
        check("berr_subcycles", 32'(subCycles - s0), 32'd1);

        // No acknowledge: timeout
        pushBus(32'h6000, 2'b00, 1'b1, 0, 0, 2'b11, 1'b1, 0);
        doReq(1'b1, 2'b00, 32'h6000, 0, 32'd0, 0, 1, 0);

        // Misaligned long and word: no bus activity
        s0 = subCycles;
        doReq(1'b1, 2'b00, 32'h4002, 0, 32'd0, 0, 0, 1);
        doReq(1'b0, 2'b10, 32'h3001, 32'h1111, 32'd0, 0, 0, 1);
        check("align_subcycles", 32'(subCycles - s0), 32'd0);

        // Reset while waiting for acknowledge on a write
        pushBus(32'h7000, 2'b10, 1'b0, 32'hCAFECAFE, 32'hFFFFFFFF, 2'b11, 1'b1, 0);
        issue(1'b0, 2'b10, 32'h7000, 32'h0000CAFE);
        n = 0;
        while (nBusDS && n < 50) begin @(negedge sysClk); n++; end
        check("rst_dsSeen", 32'(nBusDS), 32'd0);
        @(negedge sysClk);
        check("rst_preOe", 32'(busDataOe), 32'd1);
        sysReset = 1'b1;
        @(posedge sysClk);
        #1;
        check("midrst_nBusAS", 32'(nBusAS), 32'd1);
        check("midrst_nBusDS", 32'(nBusDS), 32'd1);
        check("midrst_busDataOe", 32'(busDataOe), 32'd0);
        check("midrst_rspValid", 32'(rspValid), 32'd0);
        @(negedge sysClk);
        sysReset = 1'b0;
        seenRsp = 1'b0;
        repeat (8) begin
            @(negedge sysClk);
            if (rspValid) seenRsp = 1'b1;
        end
        check("midrst_noRsp", 32'(seenRsp), 32'd0);
        check("midrst_reqReady", 32'(reqReady), 32'd1);

        // Recovery after reset
        pushBus(32'h1004, 2'b00, 1'b1, 0, 0, 2'b00, 1'b1, 32'h0BADF00D);
        doReq(1'b1, 2'b00, 32'h1004, 0, 32'h0BADF00D, 0, 0, 0);

        check("busExp_drained", 32'(busExp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
